// File: rtl/div_seq_ctrl_pkg.sv
// Shared encodings for the multi-cycle divide sequencer: operation select
// codes (RISC-V funct3 values) and the sequencer state type.
package div_seq_ctrl_pkg;

    localparam int FUNCT_W = 3;

    localparam logic [FUNCT_W-1:0] FUNCT_DIV  = 3'b100;
    localparam logic [FUNCT_W-1:0] FUNCT_DIVU = 3'b101;
    localparam logic [FUNCT_W-1:0] FUNCT_REM  = 3'b110;
    localparam logic [FUNCT_W-1:0] FUNCT_REMU = 3'b111;

    typedef enum logic [2:0] {
        DIV_IDLE = 3'd0,
        DIV_PREP = 3'd1,
        DIV_CALC = 3'd2,
        DIV_FIX  = 3'd3,
        DIV_DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder, try subtracting the divisor, keep the result if it did
// not go negative and record the outcome as the next quotient bit.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    // The shifted remainder keeps its top bit so that divisors at or above
    // 2^(XLEN-1) still divide correctly on the unsigned path.
    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    assign shifted = {rem, quo[XLEN-1]};
    assign trial   = shifted - {1'b0, divisor};

    // Restore on a negative trial, otherwise accept the subtraction.
    assign rem_next = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    assign quo_next = {quo[XLEN-2:0], ~trial[XLEN]};

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer: latch operands, fix signs,
// iterate one quotient bit per cycle, correct signs, pulse done.
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [XLEN-1:0]    operand_1,
    input  logic [XLEN-1:0]    operand_2,
    input  logic               flush,
    output logic               stall_req,
    output logic               done,
    output logic [XLEN-1:0]    result
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e         state, state_nxt;
    logic [FUNCT_W-1:0] funct_q;
    logic [XLEN-1:0]    a_q, b_q, abs_b, rem, quo;
    logic [CNT_W-1:0]   cnt;
    logic               neg_q, neg_r;

    logic               is_signed, want_rem, div_zero, overflow;
    logic [XLEN-1:0]    abs_a_c, abs_b_c, rem_step, quo_step, fix_q, fix_r;

    assign is_signed = (funct_q == FUNCT_DIV) || (funct_q == FUNCT_REM);
    // Unrecognised codes fall to the unsigned path and return the quotient.
    assign want_rem  = (funct_q == FUNCT_REM) || (funct_q == FUNCT_REMU);
    assign abs_a_c   = (is_signed && a_q[XLEN-1]) ? -a_q : a_q;
    assign abs_b_c   = (is_signed && b_q[XLEN-1]) ? -b_q : b_q;
    assign div_zero  = (b_q == '0);
    assign overflow  = is_signed && (a_q == MIN_NEG) && (b_q == '1);
    assign fix_q     = neg_q ? -quo : quo;
    assign fix_r     = neg_r ? -rem : rem;

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (abs_b),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    assign stall_req = ((state == DIV_IDLE) && start) ||
                       (state == DIV_PREP) || (state == DIV_CALC) || (state == DIV_FIX);
    assign done      = (state == DIV_DONE);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= DIV_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode; flush returns to IDLE from anywhere.
    // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            DIV_IDLE: if (start) state_nxt = DIV_PREP;
            DIV_PREP: state_nxt = (div_zero || overflow) ? DIV_DONE : DIV_CALC;
            DIV_CALC: if (cnt == CNT_W'(1)) state_nxt = DIV_FIX;
            DIV_FIX:  state_nxt = DIV_DONE;
            DIV_DONE: state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
        if (flush) state_nxt = DIV_IDLE;
    end

    // Datapath: operand latch, sign prep, iteration, sign fix and result load.
    always_ff @(posedge clk) begin
        if (rst) begin
            funct_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            abs_b   <= '0;
            rem     <= '0;
            quo     <= '0;
            cnt     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            result  <= '0;
        end else if (!flush) begin
            unique case (state)
                DIV_IDLE: if (start) begin
                    funct_q <= funct;
                    a_q     <= operand_1;
                    b_q     <= operand_2;
                end
                DIV_PREP: begin
                    neg_q <= is_signed && (a_q[XLEN-1] ^ b_q[XLEN-1]);
                    neg_r <= is_signed && a_q[XLEN-1];
                    abs_b <= abs_b_c;
                    if (div_zero) begin
                        quo    <= '1;
                        rem    <= a_q;
                        result <= want_rem ? a_q : '1;
                    end else if (overflow) begin
                        quo    <= MIN_NEG;
                        rem    <= '0;
                        result <= want_rem ? '0 : MIN_NEG;
                    end else begin
                        rem <= '0;
                        quo <= abs_a_c;
                        cnt <= CNT_W'(XLEN);
                    end
                end
                DIV_CALC: begin
                    rem <= rem_step;
                    quo <= quo_step;
                    cnt <= cnt - CNT_W'(1);
                end
                DIV_FIX: begin
                    quo    <= fix_q;
                    rem    <= fix_r;
                    result <= want_rem ? fix_r : fix_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed cases, randomized
// operations against an arithmetic reference model, flush/reset/start rules.
module tb_div_seq_ctrl;
    import div_seq_ctrl_pkg::*;

    localparam int XLEN   = 32;
    localparam int MAXCYC = 60;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [FUNCT_W-1:0] funct;
    logic [XLEN-1:0]    operand_1, operand_2;
    logic               flush;
    logic               stall_req, done;
    logic [XLEN-1:0]    result;

    int tests_run = 0;
    int failed    = 0;
    logic [XLEN-1:0] last_expect = '0;

    div_seq_ctrl #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct     (funct),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .flush     (flush),
        .stall_req (stall_req),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    // Reference model from the architectural rules, plain arithmetic.
    function automatic logic [XLEN-1:0] ref_result(logic [FUNCT_W-1:0] f,
                                                   logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        logic sgn, rsel;
        logic signed [XLEN-1:0] sa, sb;
        sgn  = (f == FUNCT_DIV) || (f == FUNCT_REM);
        rsel = (f == FUNCT_REM) || (f == FUNCT_REMU);
        sa = a;
        sb = b;
        if (b == 0) return rsel ? a : '1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rsel ? '0 : 32'h8000_0000;
        if (sgn) return rsel ? XLEN'(sa % sb) : XLEN'(sa / sb);
        return rsel ? a % b : a / b;
    endfunction

    function automatic int ref_latency(logic [FUNCT_W-1:0] f, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        logic sgn;
        sgn = (f == FUNCT_DIV) || (f == FUNCT_REM);
        if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
        return XLEN + 3;
    endfunction

    // Issue one op with start for a single cycle (cycle 0), wait for done.
    task automatic run_op(input logic [FUNCT_W-1:0] f, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, output logic [XLEN-1:0] res,
                          output int lat, output bit stall_ok);
        @(negedge clk);
        funct = f; operand_1 = a; operand_2 = b; start = 1'b1;
        #1;
        stall_ok = (stall_req === 1'b1);
        lat = -1;
        res = 'x;
        for (int c = 1; c <= MAXCYC; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (done === 1'b1) begin
                lat = c;
                res = result;
                if (stall_req !== 1'b0) stall_ok = 0;
                break;
            end
            if (stall_req !== 1'b1) stall_ok = 0;
        end
    endtask

    task automatic check_op(input string name, input logic [FUNCT_W-1:0] f,
                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input logic [XLEN-1:0] exp_res, input int exp_lat);
        logic [XLEN-1:0] res;
        int lat;
        bit sok;
        run_op(f, a, b, res, lat, sok);
        tests_run++;
        if (lat !== exp_lat) begin
            failed++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        tests_run++;
        if (res !== exp_res) begin
            failed++;
            $display("FAIL %s result: got %h expected %h (a=%h b=%h f=%0d)", name, res, exp_res, a, b, f);
        end
        tests_run++;
        if (!sok) begin
            failed++;
            $display("FAIL %s stall_req: not high through cycles 0..%0d or high at done", name, exp_lat - 1);
        end
        last_expect = exp_res;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; funct = '0; operand_1 = '0; operand_2 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (done !== 1'b0 || stall_req !== 1'b0 || result !== '0) begin
            failed++;
            $display("FAIL reset: done=%b stall=%b result=%h expected 0/0/0", done, stall_req, result);
        end
        last_expect = '0;
    endtask

    task automatic test_directed();
        check_op("divu_100_7", FUNCT_DIVU, 100, 7, 14, 35);
        check_op("remu_100_7", FUNCT_REMU, 100, 7, 2, 35);
        check_op("div_m7_2",   FUNCT_DIV, -32'sd7, 2, 32'hFFFF_FFFD, 35);
        check_op("rem_m7_2",   FUNCT_REM, -32'sd7, 2, 32'hFFFF_FFFF, 35);
        check_op("rem_7_m2",   FUNCT_REM, 7, -32'sd2, 1, 35);
        check_op("div_5_0",    FUNCT_DIV, 5, 0, 32'hFFFF_FFFF, 2);
        check_op("remu_5_0",   FUNCT_REMU, 5, 0, 5, 2);
        check_op("div_ovf",    FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        check_op("rem_ovf",    FUNCT_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 2);
        check_op("divu_big",   FUNCT_DIVU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 35);
        check_op("remu_big",   FUNCT_REMU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35);
        check_op("bad_funct",  3'b010, 50, 6, 8, 35);
    endtask

    function automatic logic [XLEN-1:0] pick_operand();
        logic [XLEN-1:0] specials [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        case ($urandom_range(0, 3))
            0: return specials[$urandom_range(0, 4)];
            1: return XLEN'($urandom_range(0, 200)) - 100;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [FUNCT_W-1:0] f;
        logic [XLEN-1:0] a, b;
        for (int i = 0; i < 40; i++) begin
            f = FUNCT_W'($urandom_range(0, 7));
            if (f < 3'b100 && $urandom_range(0, 3) != 0) f = f | 3'b100;
            a = pick_operand();
            b = pick_operand();
            check_op($sformatf("rand%0d", i), f, a, b, ref_result(f, a, b), ref_latency(f, a, b));
        end
    endtask

    task automatic test_flush();
        bit saw_done = 0;
        @(negedge clk);
        funct = FUNCT_DIVU; operand_1 = 32'hFFFF_FFFF; operand_2 = 1; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (done === 1'b1) saw_done = 1;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        tests_run++;
        if (saw_done || done !== 1'b0 || stall_req !== 1'b0 || result !== last_expect) begin
            failed++;
            $display("FAIL flush_abort: saw_done=%b done=%b stall=%b result=%h expected 0/0/0/%h",
                     saw_done, done, stall_req, result, last_expect);
        end
        check_op("after_flush_9_3", FUNCT_DIVU, 9, 3, 3, 35);
        // flush together with start in IDLE drops the request
        @(negedge clk);
        funct = FUNCT_DIVU; operand_1 = 20; operand_2 = 4; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        saw_done = 0;
        tests_run++;
        if (stall_req !== 1'b0) begin
            failed++;
            $display("FAIL flush_start_idle stall: got %b expected 0", stall_req);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) saw_done = 1;
        end
        tests_run++;
        if (saw_done) begin
            failed++;
            $display("FAIL flush_start_idle done: got pulse expected none");
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done = 0;
        @(negedge clk);
        funct = FUNCT_DIV; operand_1 = 1000; operand_2 = 7; start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (done !== 1'b0 || result !== '0 || stall_req !== 1'b0) begin
            failed++;
            $display("FAIL reset_mid_calc: done=%b result=%h stall=%b expected 0/0/0", done, result, stall_req);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) saw_done = 1;
        end
        tests_run++;
        if (saw_done) begin
            failed++;
            $display("FAIL reset_mid_calc late done: got pulse expected none");
        end
        last_expect = '0;
    endtask

    task automatic test_start_in_done();
        bit saw_done = 0;
        check_op("pre_done_div", FUNCT_DIVU, 77, 5, 15, 35);
        // still inside the DONE cycle: this start must be ignored
        funct = FUNCT_DIVU; operand_1 = 8; operand_2 = 2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) saw_done = 1;
        end
        tests_run++;
        if (saw_done || result !== last_expect) begin
            failed++;
            $display("FAIL start_in_done: saw_done=%b result=%h expected 0/%h", saw_done, result, last_expect);
        end
    endtask

    task automatic test_back_to_back();
        check_op("b2b_1", FUNCT_REMU, 1234, 10, 4, 35);
        check_op("b2b_2", FUNCT_DIV, -32'sd100, -32'sd9, 11, 35);
        check_op("b2b_3", FUNCT_REMU, 9, 0, 9, 2);
        check_op("b2b_4", FUNCT_REM, -32'sd100, -32'sd9, 32'hFFFF_FFFF, 35);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_reset_mid();
        test_start_in_done();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
